// File: rtl/sr_pkg.sv
// Shared constants for the SR register bank: conflict-resolution modes and
// legal parameter ranges.
package sr_pkg;

    localparam int unsigned SR_RST_DOM = 0;
    localparam int unsigned SR_SET_DOM = 1;
    localparam int unsigned SR_TOGGLE  = 2;
    localparam int unsigned SR_HOLD    = 3;

    localparam int unsigned SR_WIDTH_MIN = 1;
    localparam int unsigned SR_WIDTH_MAX = 64;
    localparam int unsigned SR_CNT_W_MIN = 1;
    localparam int unsigned SR_CNT_W_MAX = 16;

endpackage

// File: rtl/sr_cell.sv
// One SR channel: registered q, one-cycle change pulse and sticky conflict flag.
module sr_cell
    import sr_pkg::*;
#(
    parameter int unsigned MODE     = SR_RST_DOM,
    parameter logic        INIT_BIT = 1'b0
) (
    input  logic clk,
    input  logic rstbar,
    input  logic i_sbar,
    input  logic i_rbar,
    input  logic i_clr_err,
    output logic o_q,
    output logic o_q_chg,
    output logic o_conflict,
    output logic o_conflict_now
);

    logic r_q;
    logic r_q_chg;
    logic r_conflict;
    logic w_q_next;
    logic w_conflict_now;

    assign w_conflict_now = ~i_sbar & ~i_rbar;

    always_comb begin
        w_q_next = r_q;
        unique case ({i_sbar, i_rbar})
            2'b01:   w_q_next = 1'b1;
            2'b10:   w_q_next = 1'b0;
            2'b11:   w_q_next = r_q;
            default: begin
                case (MODE)
                    SR_RST_DOM: w_q_next = 1'b0;
                    SR_SET_DOM: w_q_next = 1'b1;
                    SR_TOGGLE:  w_q_next = ~r_q;
                    default:    w_q_next = r_q;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstbar) begin
            r_q        <= INIT_BIT;
            r_q_chg    <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_q        <= w_q_next;
            r_q_chg    <= w_q_next ^ r_q;
            // Clear wins over a conflict sampled on the same edge.
            r_conflict <= i_clr_err ? 1'b0 : (r_conflict | w_conflict_now);
        end
    end

    assign o_q            = r_q;
    assign o_q_chg        = r_q_chg;
    assign o_conflict     = r_conflict;
    assign o_conflict_now = w_conflict_now;

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of independent SR channels with sticky per-channel conflict flags and a
// saturating count of cycles in which any channel conflicted.
module sr_reg_bank
    import sr_pkg::*;
#(
    parameter int unsigned       WIDTH = 8,
    parameter int unsigned       MODE  = SR_RST_DOM,
    parameter logic [WIDTH-1:0]  INIT  = '0,
    parameter int unsigned       CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstbar,
    input  logic [WIDTH-1:0] sbar,
    input  logic [WIDTH-1:0] rbar,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] q_chg,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    if (MODE > SR_HOLD) begin : g_bad_mode
        $error("sr_reg_bank: MODE must be 0..3");
    end
    if (WIDTH < SR_WIDTH_MIN || WIDTH > SR_WIDTH_MAX) begin : g_bad_width
        $error("sr_reg_bank: WIDTH must be 1..64");
    end
    if (CNT_W < SR_CNT_W_MIN || CNT_W > SR_CNT_W_MAX) begin : g_bad_cnt_w
        $error("sr_reg_bank: CNT_W must be 1..16");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_conflict_now;
    logic             w_any_conflict;
    logic [CNT_W-1:0] r_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE     (MODE),
            .INIT_BIT (INIT[i])
        ) u_cell (
            .clk            (clk),
            .rstbar         (rstbar),
            .i_sbar         (sbar[i]),
            .i_rbar         (rbar[i]),
            .i_clr_err      (clr_err),
            .o_q            (q[i]),
            .o_q_chg        (q_chg[i]),
            .o_conflict     (conflict[i]),
            .o_conflict_now (w_conflict_now[i])
        );
    end

    assign w_any_conflict = |w_conflict_now;

    always_ff @(posedge clk) begin
        if (!rstbar) begin
            r_cnt <= '0;
        end else if (clr_err) begin
            r_cnt <= '0;
        end else if (w_any_conflict && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign qbar         = ~q;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench for sr_reg_bank: one instance per MODE plus a narrow-counter,
// non-zero INIT instance, all sharing the same stimulus.
module tb_sr_reg_bank;

    logic       clk = 1'b0;
    logic       rstbar;
    logic       clr_err;
    logic [7:0] sbar;
    logic [7:0] rbar;

    logic [7:0] q_a   [5];
    logic [7:0] qb_a  [5];
    logic [7:0] chg_a [5];
    logic [7:0] cf_a  [5];
    logic [3:0] cnt_a [4];
    logic [1:0] cnt4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_mode
        sr_reg_bank #(
            .WIDTH (8),
            .MODE  (m),
            .INIT  (8'h00),
            .CNT_W (4)
        ) u_dut (
            .clk          (clk),
            .rstbar       (rstbar),
            .sbar         (sbar),
            .rbar         (rbar),
            .clr_err      (clr_err),
            .q            (q_a[m]),
            .qbar         (qb_a[m]),
            .q_chg        (chg_a[m]),
            .conflict     (cf_a[m]),
            .conflict_cnt (cnt_a[m])
        );
    end

    sr_reg_bank #(
        .WIDTH (8),
        .MODE  (2),
        .INIT  (8'hA5),
        .CNT_W (2)
    ) u_dut4 (
        .clk          (clk),
        .rstbar       (rstbar),
        .sbar         (sbar),
        .rbar         (rbar),
        .clr_err      (clr_err),
        .q            (q_a[4]),
        .qbar         (qb_a[4]),
        .q_chg        (chg_a[4]),
        .conflict     (cf_a[4]),
        .conflict_cnt (cnt4)
    );

    typedef struct {
        logic       rb;
        logic [7:0] s;
        logic [7:0] r;
        logic       c;
        logic [7:0] q;
        logic [7:0] chg;
        logic [7:0] cf;
        logic [3:0] cnt;
    } vec_t;

    vec_t vt[12];

    task automatic step(input logic rb, input logic [7:0] s, input logic [7:0] r,
                        input logic c);
        rstbar  = rb;
        sbar    = s;
        rbar    = r;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        // MODE 0, INIT 0, CNT_W 4 expectations for instance 0.
        vt[0]  = '{1'b1, 8'hFE, 8'hFF, 1'b0, 8'h01, 8'h01, 8'h00, 4'd0};
        vt[1]  = '{1'b1, 8'hFF, 8'hFE, 1'b0, 8'h00, 8'h01, 8'h00, 4'd0};
        vt[2]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 4'd0};
        vt[3]  = '{1'b1, 8'h0F, 8'hFF, 1'b0, 8'hF0, 8'hF0, 8'h00, 4'd0};
        vt[4]  = '{1'b1, 8'hF0, 8'h3F, 1'b0, 8'h3F, 8'hCF, 8'h00, 4'd0};
        vt[5]  = '{1'b1, 8'hF7, 8'hF7, 1'b0, 8'h37, 8'h08, 8'h08, 4'd1};
        vt[6]  = '{1'b1, 8'h7F, 8'h7F, 1'b0, 8'h37, 8'h00, 8'h88, 4'd2};
        vt[7]  = '{1'b1, 8'hFE, 8'hFE, 1'b1, 8'h36, 8'h01, 8'h00, 4'd0};
        vt[8]  = '{1'b1, 8'hFE, 8'hFE, 1'b0, 8'h36, 8'h00, 8'h01, 4'd1};
        vt[9]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 8'h36, 8'h00, 8'h01, 4'd1};
        vt[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 4'd0};
        vt[11] = '{1'b1, 8'hFB, 8'hFF, 1'b0, 8'h04, 8'h04, 8'h00, 4'd0};

        // Two-cycle reset with conflicting requests that must be ignored.
        step(1'b0, 8'h00, 8'h00, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b1);
        check("rst4_q",    {8'h0, q_a[4]},  16'h00A5);
        check("rst4_qbar", {8'h0, qb_a[4]}, 16'h005A);
        check("rst4_chg",  {8'h0, chg_a[4]}, 16'h0000);
        check("rst4_cf",   {8'h0, cf_a[4]}, 16'h0000);
        check("rst4_cnt",  {14'h0, cnt4},   16'h0000);
        check("rst0_q",    {8'h0, q_a[0]},  16'h0000);
        check("rst0_qbar", {8'h0, qb_a[0]}, 16'h00FF);

        for (int i = 0; i < 12; i++) begin
            step(vt[i].rb, vt[i].s, vt[i].r, vt[i].c);
            check($sformatf("vec%0d_q", i),    {8'h0, q_a[0]},   {8'h0, vt[i].q});
            check($sformatf("vec%0d_qbar", i), {8'h0, qb_a[0]},  {8'h0, ~vt[i].q});
            check($sformatf("vec%0d_chg", i),  {8'h0, chg_a[0]}, {8'h0, vt[i].chg});
            check($sformatf("vec%0d_cf", i),   {8'h0, cf_a[0]},  {8'h0, vt[i].cf});
            check($sformatf("vec%0d_cnt", i),  {12'h0, cnt_a[0]}, {12'h0, vt[i].cnt});
        end

        // Three conflict edges on channel 3 starting from q[3]=1, per MODE.
        step(1'b0, 8'hFF, 8'hFF, 1'b0);
        step(1'b1, 8'hF7, 8'hFF, 1'b0);
        check("m2_pre_q", {8'h0, q_a[2]}, 16'h0008);
        step(1'b1, 8'hF7, 8'hF7, 1'b0);
        check("m2_tog1_q", {8'h0, q_a[2]}, 16'h0000);
        step(1'b1, 8'hF7, 8'hF7, 1'b0);
        check("m2_tog2_q", {8'h0, q_a[2]}, 16'h0008);
        step(1'b1, 8'hF7, 8'hF7, 1'b0);
        check("m0_q",   {8'h0, q_a[0]}, 16'h0000);
        check("m1_q",   {8'h0, q_a[1]}, 16'h0008);
        check("m2_q",   {8'h0, q_a[2]}, 16'h0000);
        check("m3_q",   {8'h0, q_a[3]}, 16'h0008);
        check("m2_chg", {8'h0, chg_a[2]}, 16'h0008);
        check("m3_chg", {8'h0, chg_a[3]}, 16'h0000);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("m%0d_cf", m),  {8'h0, cf_a[m]},   16'h0008);
            check($sformatf("m%0d_cnt", m), {12'h0, cnt_a[m]}, 16'h0003);
        end

        // Narrow counter saturation with every channel conflicting.
        step(1'b0, 8'hFF, 8'hFF, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 8'h00, 8'h00, 1'b0);
            check($sformatf("sat_cnt%0d", k), {14'h0, cnt4}, (k < 3) ? k[15:0] : 16'd3);
        end
        check("sat_cf", {8'h0, cf_a[4]}, 16'h00FF);
        check("sat_q",  {8'h0, q_a[4]},  16'h00A5);

        // Reset during active toggling: nothing from that edge survives.
        step(1'b0, 8'h00, 8'h00, 1'b0);
        check("rtog2_q",   {8'h0, q_a[2]},  16'h0000);
        check("rtog2_chg", {8'h0, chg_a[2]}, 16'h0000);
        check("rtog2_cnt", {12'h0, cnt_a[2]}, 16'h0000);
        check("rtog4_q",   {8'h0, q_a[4]},  16'h00A5);
        check("rtog4_qb",  {8'h0, qb_a[4]}, 16'h005A);
        check("rtog4_chg", {8'h0, chg_a[4]}, 16'h0000);
        check("rtog4_cf",  {8'h0, cf_a[4]}, 16'h0000);
        check("rtog4_cnt", {14'h0, cnt4},   16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
